// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment scanner with per-frame snapshot,
// leading-zero blanking, decimal points and an all-off guard gap between digits.
module seg7_scan #(
  parameter int unsigned N_DIG = 3,
  parameter int unsigned DWELL = 50000,
  parameter int unsigned GAP   = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*N_DIG-1:0] bcd,
  input  logic [N_DIG-1:0]   dp,
  input  logic               lz_en,
  output logic [N_DIG-1:0]   an,
  output logic [6:0]         seg,
  output logic               dp_n,
  output logic               frame_tick
);

  localparam int unsigned MaxCnt = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
  localparam int unsigned IW     = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CW-1:0] GapLast   = CW'(GAP - 1);
  localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(N_DIG - 1);

  typedef enum logic {StGap, StShow} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] snap_q, snap_d;
  logic [N_DIG-1:0]   dp_snap_q, dp_snap_d;
  logic               wrap;
  logic [3:0]         nib;
  logic [6:0]         dec;
  logic               blank;
  logic [N_DIG-1:0]   an_d;
  logic [6:0]         seg_d;
  logic               dp_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    unique case (state_q)
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end
      end
      StShow: begin
        if (cnt_q == DwellLast) begin
          state_d = StGap;
          cnt_d   = '0;
          if (idx_q == IdxLast) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StGap;
    endcase
    snap_d    = wrap ? bcd : snap_q;
    dp_snap_d = wrap ? dp  : dp_snap_q;
  end

  // Outputs are computed from the next state so the registers track the state exactly.
  always_comb begin
    nib = snap_d[{idx_d, 2'b00} +: 4];
    case (nib)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
    blank = lz_en && (idx_d != '0);
    for (int j = 0; j < N_DIG; j++) begin
      if ((IW'(j) >= idx_d) && ((snap_d[4*j +: 4] != 4'h0) || dp_snap_d[j])) begin
        blank = 1'b0;
      end
    end
    if (state_d == StShow) begin
      an_d   = ~(N_DIG'(1) << idx_d);
      seg_d  = blank ? 7'h7F : dec;
      dp_n_d = ~dp_snap_d[idx_d];
    end else begin
      an_d   = '1;
      seg_d  = 7'h7F;
      dp_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StGap;
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      dp_snap_q  <= '0;
      an         <= '1;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      dp_snap_q  <= dp_snap_d;
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= dp_n_d;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a frame-position model (t mod frame) predicts every output each cycle.
module tb_seg7_scan;
  localparam int N = 3, DW = 4, GP = 1, SLOT = DW + GP, FRAME = N * SLOT;

  logic clk = 1'b0, rst_n = 1'b0, lz_en = 1'b1;
  logic [11:0] bcd = '0;
  logic [2:0]  dp = '0;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        dp_n, frame_tick;

  seg7_scan #(.N_DIG(N), .DWELL(DW), .GAP(GP)) dut (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp(dp), .lz_en(lz_en),
    .an(an), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0;
  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                               7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Reference: cycles since release, the word captured at each frame boundary, live lz_en.
  int t;
  logic [11:0] ms;
  logic [2:0]  md;
  logic        mlz;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t <= 0; ms <= '0; md <= '0; mlz <= 1'b0;
    end else begin
      t   <= t + 1;
      mlz <= lz_en;
      if ((t + 1) % FRAME == 0) begin
        ms <= bcd;
        md <= dp;
      end
    end
  end

  function automatic logic [11:0] model_out(int tt, logic [11:0] s, logic [2:0] d, logic lz);
    int p, dig;
    logic ft, blank;
    logic [2:0] a;
    logic [3:0] nb;
    p  = tt % FRAME;
    ft = (tt > 0) && (p == 0);
    if (p % SLOT < GP) return {3'b111, 7'h7F, 1'b1, ft};
    dig   = p / SLOT;
    a     = 3'b111;
    a[dig] = 1'b0;
    nb    = 4'((s >> (4 * dig)) & 12'hF);
    blank = lz && (dig > 0) && ((s >> (4 * dig)) == 0) && ((d >> dig) == 0);
    return {a, blank ? 7'h7F : dec_tab[nb], ~d[dig], ft};
  endfunction

  task automatic test_reset();
    logic [11:0] exp;
    int first;
    rst_n = 1'b0; bcd = 12'h000; dp = 3'b000; lz_en = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({an, seg, dp_n, frame_tick} !== {3'b111, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_state got %h exp %h", {an, seg, dp_n, frame_tick},
               {3'b111, 7'h7F, 1'b1, 1'b0});
    else pass_cnt++;
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 2 * FRAME && first < 0; i++) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL first_frame t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
      if (frame_tick) first = i;
    end
    chk_cnt++;
    if (first !== FRAME) $display("FAIL first_tick got %0d exp %0d", first, FRAME);
    else pass_cnt++;
  endtask

  task automatic test_digits();
    logic [11:0] exp;
    bcd = 12'h123; lz_en = 1'b0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL digits_123 t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_lz_dp();
    logic [11:0] exp;
    bcd = 12'h005; dp = 3'b010; lz_en = 1'b1;
    for (int i = 0; i < 3 * FRAME + 7; i++) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL lz_dp t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
      if (i == 2 * FRAME + 6) lz_en = 1'b0;
    end
    dp = 3'b000;
  endtask

  task automatic test_snapshot();
    logic [11:0] exp;
    int guard;
    bcd = 12'h111; lz_en = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!frame_tick && guard < 4 * FRAME);
    do begin @(negedge clk); guard++; end while ((t % FRAME) != SLOT + GP + 1 && guard < 6 * FRAME);
    chk_cnt++;
    if (guard >= 6 * FRAME) $display("FAIL snap_wait got timeout exp digit1");
    else pass_cnt++;
    bcd = 12'h999;
    repeat (2 * FRAME) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL snapshot t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_dash();
    logic [11:0] exp;
    bcd = 12'h0A7; lz_en = 1'b1;
    repeat (3 * FRAME) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL dash t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    int low;
    repeat (20 * FRAME) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL random t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
      low = 0;
      for (int k = 0; k < N; k++) if (!an[k]) low++;
      chk_cnt++;
      if (low > 1) $display("FAIL one_hot_an got %b exp at most one low", an);
      else pass_cnt++;
      if ($urandom_range(0, 6) == 0) begin
        for (int k = 0; k < N; k++)
          bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        dp = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      end
      if ($urandom_range(0, 9) == 0) lz_en = ~lz_en;
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    int guard;
    bcd = 12'h456; lz_en = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while ((t % FRAME) != 2 * SLOT + GP + 1 && guard < 4 * FRAME);
    chk_cnt++;
    if (guard >= 4 * FRAME) $display("FAIL rst_wait got timeout exp digit2");
    else pass_cnt++;
    chk_cnt++;
    if (an !== 3'b011) $display("FAIL pre_rst_an got %b exp 011", an);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({an, seg, frame_tick} !== {3'b111, 7'h7F, 1'b0})
      $display("FAIL async_rst got %b/%b exp 111/1111111", an, seg);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_cnt++;
    if (an !== 3'b111) $display("FAIL post_rst_gap got %b exp 111", an);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (an !== 3'b110) $display("FAIL post_rst_d0 got %b exp 110", an);
    else pass_cnt++;
    repeat (2 * FRAME) begin
      @(negedge clk);
      exp = model_out(t, ms, md, mlz);
      chk_cnt++;
      if ({an, seg, dp_n, frame_tick} !== exp)
        $display("FAIL after_rst t=%0d got %h exp %h", t, {an, seg, dp_n, frame_tick}, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_lz_dp();
    test_snapshot();
    test_dash();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
